// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types and constants for the word memory responder
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port synchronous word RAM with registered read data, no reset
module mem_responder_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata only moves on an enabled access so the top can hold it between responses
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - load/store/fetch responder with wait states; optional MEM_RESPONDER_ERR_CHECK_EN address fault check
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int             IDX_W    = idx_w(DEPTH_WORDS);
  localparam bit             HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = HAS_WAIT ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               write_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        wdata_q;
  logic               fault_q;
  logic               zero_q;
  logic               err_q;

  logic               accept;
  logic               req_fault;
  logic               to_resp;
  logic               cur_write;
  logic               cur_fault;
  logic [IDX_W-1:0]   cur_idx;
  logic [31:0]        cur_wdata;
  logic [31:0]        ram_rdata;

  assign req_ready = reset && (state == IDLE);
  assign accept    = req_valid && req_ready;

`ifdef MEM_RESPONDER_ERR_CHECK_EN
  assign req_fault = (req_addr[1:0] != 2'b00) ||
                     (64'(req_addr) >= 64'(DEPTH_WORDS) * 64'd4);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
  assign req_fault        = 1'b0;
`endif

  // With zero wait states the RAM access happens in the accept cycle, straight from the request
  always_comb begin
    cur_write = write_q;
    cur_fault = fault_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_write = req_write;
      cur_fault = req_fault;
      cur_idx   = req_addr[IDX_W+1:2];
      cur_wdata = req_wdata;
    end
  end

  assign to_resp = ((state == IDLE) && accept && !HAS_WAIT) ||
                   ((state == WAIT) && (cnt == '0));

  mem_responder_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (to_resp),
    .we   (cur_write && !cur_fault),
    .idx  (cur_idx),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      fault_q   <= 1'b0;
      rsp_valid <= 1'b0;
      zero_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
            fault_q <= req_fault;
            cnt     <= CNT_LOAD;
            state   <= HAS_WAIT ? WAIT : RESP;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // Stores and faults answer with zero data; loads expose the RAM read register
      if (to_resp) begin
        rsp_valid <= 1'b1;
        zero_q    <= cur_write || cur_fault;
        err_q     <= cur_fault;
      end
    end
  end

  assign rsp_rdata = zero_q ? 32'd0 : ram_rdata;

`ifdef MEM_RESPONDER_ERR_CHECK_EN
  assign rsp_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        z_valid, z_write, z_ready, z_rsp_valid, z_err;
  logic [31:0] z_addr, z_wdata, z_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem_m [DEPTH];
  bit          known [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_write(z_write), .req_addr(z_addr), .req_wdata(z_wdata),
    .req_ready(z_ready), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  function automatic bit m_err(input logic [31:0] a);
`ifdef MEM_RESPONDER_ERR_CHECK_EN
    return (a % 4 != 0) || (64'(a) >= 64'(4 * DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] ex_rd, output logic ex_e, output bit ex_k);
    int i;
    i     = int'((a / 4) % DEPTH);
    ex_e  = m_err(a);
    ex_k  = 1'b1;
    ex_rd = 32'd0;
    if (ex_e) return;
    if (w) begin
      mem_m[i] = d;
      known[i] = 1'b1;
    end else begin
      ex_rd = mem_m[i];
      ex_k  = known[i];
    end
  endfunction

  // Returns lat = -1 if the request was never accepted or never answered
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = -1; rd = 'x; e = 'x;
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; e = rsp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    z_valid = 0; z_write = 0; z_addr = 0; z_wdata = 0;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", rsp_err); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%0b exp=1", req_ready); end
    checks++; if (z_ready !== 1'b1) begin errors++; $display("FAIL release_ready_w0 got=%0b exp=1", z_ready); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, ex_rd; logic e, ex_e; bit ex_k; int lat;
    xfer(1'b1, 32'h010, 32'hDEADBEEF, rd, e, lat);
    model(1'b1, 32'h010, 32'hDEADBEEF, ex_rd, ex_e, ex_k);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL store_rsp got=%h/%0b exp=0/0", rd, e); end
    xfer(1'b0, 32'h010, 32'h0, rd, e, lat);
    model(1'b0, 32'h010, 32'h0, ex_rd, ex_e, ex_k);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL load_data got=%h/%0b exp=deadbeef/0", rd, e); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle got=%0b exp=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold got=%h exp=deadbeef", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bd [3];
    logic [31:0] rd, ex_rd; logic e, ex_e; bit ex_k;
    int acc [3];
    int n, lowcnt, guard, lat;
    for (int i = 0; i < 3; i++) bd[i] = $urandom;
    n = 0; lowcnt = 0; guard = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h040; req_wdata = bd[0];
    while (n < 3 && guard < 60) begin
      if (req_ready) begin
        acc[n] = cyc;
        model(1'b1, 32'h040 + 32'(4 * n), bd[n], ex_rd, ex_e, ex_k);
        n++;
        @(posedge clk); #1;
        if (n < 3) begin
          req_addr = 32'h040 + 32'(4 * n); req_wdata = bd[n];
        end else begin
          req_valid = 1'b0;
        end
      end else begin
        lowcnt++;
      end
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", n); end
    if (n == 3) begin
      checks++; if (acc[1] - acc[0] !== 4) begin errors++; $display("FAIL b2b_spacing01 got=%0d exp=4", acc[1] - acc[0]); end
      checks++; if (acc[2] - acc[1] !== 4) begin errors++; $display("FAIL b2b_spacing12 got=%0d exp=4", acc[2] - acc[1]); end
      checks++; if (lowcnt !== 6) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=6", lowcnt); end
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'h040 + 32'(4 * i), 32'h0, rd, e, lat);
      model(1'b0, 32'h040 + 32'(4 * i), 32'h0, ex_rd, ex_e, ex_k);
      checks++;
      if (lat !== 3 || rd !== ex_rd) begin errors++; $display("FAIL b2b_readback%0d got=%h lat=%0d exp=%h", i, rd, lat, ex_rd); end
    end
  endtask

  task automatic test_wait0();
    logic [31:0] zd;
    int acc [2];
    int n, guard;
    zd = $urandom;
    @(negedge clk);
    z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h080; z_wdata = zd;
    checks++; if (z_ready !== 1'b1) begin errors++; $display("FAIL w0_ready got=%0b exp=1", z_ready); end
    @(posedge clk);
    @(negedge clk);
    z_valid = 1'b0;
    checks++; if (z_rsp_valid !== 1'b1 || z_rdata !== 32'd0) begin errors++; $display("FAIL w0_store_rsp got=%0b/%h exp=1/0", z_rsp_valid, z_rdata); end
    @(negedge clk);
    z_valid = 1'b1; z_write = 1'b0;
    n = 0; guard = 0;
    while (n < 2 && guard < 20) begin
      if (z_ready) begin
        acc[n] = cyc;
        n++;
        @(posedge clk); #1;
        if (n == 2) z_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (z_rsp_valid !== 1'b1 || z_rdata !== zd) begin errors++; $display("FAIL w0_load%0d got=%0b/%h exp=1/%h", n, z_rsp_valid, z_rdata, zd); end
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    z_valid = 1'b0;
    checks++; if (n !== 2 || acc[1] - acc[0] !== 2) begin errors++; $display("FAIL w0_spacing got=%0d accepts=%0d exp=2", acc[1] - acc[0], n); end
  endtask

  task automatic test_err_check();
    logic [31:0] rd, ex_rd; logic e, ex_e; bit ex_k; int lat;
    logic [31:0] addrs [6];
    logic        wr    [6];
    logic [31:0] dat   [6];
    addrs = '{32'h010, 32'h000, 32'h013, 32'h400, 32'h010, 32'h000};
    wr    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    dat   = '{$urandom, $urandom, 32'h12345678, 32'h12345678, 32'h0, 32'h0};
    for (int i = 0; i < 6; i++) begin
      xfer(wr[i], addrs[i], dat[i], rd, e, lat);
      model(wr[i], addrs[i], dat[i], ex_rd, ex_e, ex_k);
      checks++;
      if (lat !== 3 || e !== ex_e || rd !== ex_rd) begin
        errors++;
        $display("FAIL err_step%0d addr=%h got=%h/%0b lat=%0d exp=%h/%0b", i, addrs[i], rd, e, lat, ex_rd, ex_e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, ex_rd, pd; logic e, ex_e; bit ex_k; int lat;
    bit seen;
    pd = $urandom;
    xfer(1'b1, 32'h020, pd, rd, e, lat);
    model(1'b1, 32'h020, pd, ex_rd, ex_e, ex_k);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h020; req_wdata = 32'hAAAA5555;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midwait_ready got=%0b exp=1", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || req_ready) seen = 1'b1;
    end
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midwait_no_rsp got=%0b exp=0", seen); end
    xfer(1'b0, 32'h020, 32'h0, rd, e, lat);
    model(1'b0, 32'h020, 32'h0, ex_rd, ex_e, ex_k);
    checks++; if (lat !== 3 || rd !== ex_rd) begin errors++; $display("FAIL midwait_readback got=%h lat=%0d exp=%h", rd, lat, ex_rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, ex_rd, a, d; logic e, ex_e, w; bit ex_k; int lat;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 8 * DEPTH - 1));
      else a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      d = $urandom;
      xfer(w, a, d, rd, e, lat);
      model(w, a, d, ex_rd, ex_e, ex_k);
      checks++;
      if (lat !== 3 || e !== ex_e || (ex_k && rd !== ex_rd)) begin
        errors++;
        $display("FAIL rand%0d w=%0b addr=%h got=%h/%0b lat=%0d exp=%h/%0b", i, w, a, rd, e, lat, ex_rd, ex_e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wait0();
    test_err_check();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
